// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Ordered reset sequencer for a group of bsg_link_sdr channels and their core.
// Ports: clk_i, reset_n_i (sync active-low), restart_i in; five resets and done_o out.
module bsg_link_sdr_reset_sequencer #(
  parameter int token_cycles_p = 4,
  parameter int wait_cycles_p  = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic restart_i,
  output logic async_token_reset_o,
  output logic async_uplink_reset_o,
  output logic async_downlink_reset_o,
  output logic async_downstream_reset_o,
  output logic core_reset_o,
  output logic done_o
);

  localparam int max_lp =
    (token_cycles_p > wait_cycles_p) ? token_cycles_p : wait_cycles_p;
  localparam int ctr_width_lp = $clog2(max_lp + 1);

  localparam logic [ctr_width_lp-1:0] token_last_lp =
    ctr_width_lp'(token_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0] wait_last_lp =
    ctr_width_lp'(wait_cycles_p - 1);

  typedef enum logic [2:0] {
    eAssert,
    eToken,
    eTokenWait,
    eUplink,
    eDownlink,
    eDownstream,
    eDone
  } state_e;

  state_e                  state;
  logic [ctr_width_lp-1:0] cnt;
  logic                    last;

  // Only eToken uses the token length; every other timed state uses wait.
  always_comb begin
    last = 1'b0;
    if (state == eToken) last = (cnt == token_last_lp);
    else                 last = (cnt == wait_last_lp);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state                    <= eAssert;
      cnt                      <= '0;
      async_token_reset_o      <= 1'b0;
      async_uplink_reset_o     <= 1'b1;
      async_downlink_reset_o   <= 1'b1;
      async_downstream_reset_o <= 1'b1;
      core_reset_o             <= 1'b1;
      done_o                   <= 1'b0;
    end else begin
      unique case (state)
        eAssert: begin
          if (last) begin
            state               <= eToken;
            cnt                 <= '0;
            async_token_reset_o <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        eToken: begin
          if (last) begin
            state               <= eTokenWait;
            cnt                 <= '0;
            async_token_reset_o <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        eTokenWait: begin
          if (last) begin
            state                <= eUplink;
            cnt                  <= '0;
            async_uplink_reset_o <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        eUplink: begin
          if (last) begin
            state                  <= eDownlink;
            cnt                    <= '0;
            async_downlink_reset_o <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        eDownlink: begin
          if (last) begin
            state                    <= eDownstream;
            cnt                      <= '0;
            async_downstream_reset_o <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        eDownstream: begin
          if (last) begin
            state        <= eDone;
            cnt          <= '0;
            core_reset_o <= 1'b0;
            done_o       <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        eDone: begin
          if (restart_i) begin
            state                    <= eAssert;
            cnt                      <= '0;
            async_uplink_reset_o     <= 1'b1;
            async_downlink_reset_o   <= 1'b1;
            async_downstream_reset_o <= 1'b1;
            core_reset_o             <= 1'b1;
            done_o                   <= 1'b0;
          end
        end
        default: begin
          // Unused encoding: fall back to the full reset state.
          state                    <= eAssert;
          cnt                      <= '0;
          async_token_reset_o      <= 1'b0;
          async_uplink_reset_o     <= 1'b1;
          async_downlink_reset_o   <= 1'b1;
          async_downstream_reset_o <= 1'b1;
          core_reset_o             <= 1'b1;
          done_o                   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Bench for bsg_link_sdr_reset_sequencer: default and minimum-length instances
// checked against a timeline model (edges since sequence start).
module tb_bsg_link_sdr_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic restart;

  logic a_tok, a_up, a_dn, a_ds, a_core, a_done;
  logic b_tok, b_up, b_dn, b_ds, b_core, b_done;

  int checks;
  int errors;

  int k_a;
  int k_b;

  localparam int TA = 4, WA = 8, TOT_A = 5 * WA + TA;
  localparam int TB = 1, WB = 1, TOT_B = 5 * WB + TB;
  localparam logic [5:0] RST_VEC = 6'b011110;

  always #5 clk = ~clk;

  bsg_link_sdr_reset_sequencer #(.token_cycles_p(TA), .wait_cycles_p(WA)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .restart_i(restart),
    .async_token_reset_o(a_tok), .async_uplink_reset_o(a_up),
    .async_downlink_reset_o(a_dn), .async_downstream_reset_o(a_ds),
    .core_reset_o(a_core), .done_o(a_done)
  );

  bsg_link_sdr_reset_sequencer #(.token_cycles_p(TB), .wait_cycles_p(WB)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .restart_i(restart),
    .async_token_reset_o(b_tok), .async_uplink_reset_o(b_up),
    .async_downlink_reset_o(b_dn), .async_downstream_reset_o(b_ds),
    .core_reset_o(b_core), .done_o(b_done)
  );

  wire [5:0] out_a = {a_tok, a_up, a_dn, a_ds, a_core, a_done};
  wire [5:0] out_b = {b_tok, b_up, b_dn, b_ds, b_core, b_done};

  // Expected outputs k edges after the sequence (re)started.
  function automatic logic [5:0] exp_vec(int k, int w, int t);
    logic core;
    core = (k < 5 * w + t);
    return {(k >= w) && (k < w + t), (k < 2 * w + t), (k < 3 * w + t),
            (k < 4 * w + t), core, !core};
  endfunction

  // Reference timeline: edges since sequence start, saturating at done.
  always @(posedge clk) begin
    if (!rst_n) k_a <= 0;
    else if (k_a >= TOT_A && restart) k_a <= 0;
    else if (k_a < TOT_A) k_a <= k_a + 1;
    if (!rst_n) k_b <= 0;
    else if (k_b >= TOT_B && restart) k_b <= 0;
    else if (k_b < TOT_B) k_b <= k_b + 1;
  end

  // Release order: a later reset is never released before an earlier one.
  always @(negedge clk) begin
    assert ((a_core || !a_ds) && (a_ds || !a_dn) && (a_dn || !a_up) &&
            (!a_tok || a_up))
      else $error("order violated in dut_a");
    assert ((b_core || !b_ds) && (b_ds || !b_dn) && (b_dn || !b_up) &&
            (!b_tok || b_up))
      else $error("order violated in dut_b");
  end

  task automatic hard_reset();
    rst_n   = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    restart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_a !== RST_VEC) begin
        errors++;
        $display("FAIL reset_hold_a cyc %0d got %b exp %b", i, out_a, RST_VEC);
      end
      checks++;
      if (out_b !== RST_VEC) begin
        errors++;
        $display("FAIL reset_hold_b cyc %0d got %b exp %b", i, out_b, RST_VEC);
      end
      restart = 1'($urandom);
    end
    restart = 1'b0;
  endtask

  task automatic test_sequence();
    int done_a_edge = -1;
    int done_b_edge = -1;
    int tok_a_cnt = 0;
    int tok_b_cnt = 0;
    hard_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clk);
      checks++;
      if (out_a !== exp_vec(e, WA, TA)) begin
        errors++;
        $display("FAIL seq_a edge %0d got %b exp %b", e, out_a,
                 exp_vec(e, WA, TA));
      end
      checks++;
      if (out_b !== exp_vec(e, WB, TB)) begin
        errors++;
        $display("FAIL seq_b edge %0d got %b exp %b", e, out_b,
                 exp_vec(e, WB, TB));
      end
      if (a_done === 1'b1 && done_a_edge < 0) done_a_edge = e;
      if (b_done === 1'b1 && done_b_edge < 0) done_b_edge = e;
      if (a_tok === 1'b1) tok_a_cnt++;
      if (b_tok === 1'b1) tok_b_cnt++;
    end
    checks++;
    if (done_a_edge != 44) begin
      errors++;
      $display("FAIL done_edge_a got %0d exp 44", done_a_edge);
    end
    checks++;
    if (done_b_edge != 6) begin
      errors++;
      $display("FAIL done_edge_b got %0d exp 6", done_b_edge);
    end
    checks++;
    if (tok_a_cnt != 4 || tok_b_cnt != 1) begin
      errors++;
      $display("FAIL token_width got %0d/%0d exp 4/1", tok_a_cnt, tok_b_cnt);
    end
  endtask

  task automatic test_abort();
    int done_edge = -1;
    hard_reset();
    rst_n = 1'b1;
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_a !== RST_VEC) begin
      errors++;
      $display("FAIL abort_a got %b exp %b", out_a, RST_VEC);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 46; e++) begin
      @(negedge clk);
      checks++;
      if (out_a !== exp_vec(e, WA, TA)) begin
        errors++;
        $display("FAIL abort_seq edge %0d got %b exp %b", e, out_a,
                 exp_vec(e, WA, TA));
      end
      if (a_done === 1'b1 && done_edge < 0) done_edge = e;
    end
    checks++;
    if (done_edge != 44) begin
      errors++;
      $display("FAIL abort_done_edge got %0d exp 44", done_edge);
    end
  endtask

  task automatic test_restart();
    hard_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      restart = (e == 30 || e == 50);
      @(negedge clk);
      checks++;
      if (out_a !== exp_vec(k_a, WA, TA)) begin
        errors++;
        $display("FAIL restart_model edge %0d got %b exp %b", e, out_a,
                 exp_vec(k_a, WA, TA));
      end
      if (e == 44 || e == 50 || e == 93 || e == 94) begin
        checks++;
        if (a_done !== (e == 44 || e == 94)) begin
          errors++;
          $display("FAIL restart_done edge %0d got %b", e, a_done);
        end
      end
      if (e == 50) begin
        checks++;
        if (out_a !== RST_VEC) begin
          errors++;
          $display("FAIL restart_reassert got %b exp %b", out_a, RST_VEC);
        end
      end
    end
    restart = 1'b0;
  endtask

  task automatic test_restart_held();
    int done_cnt = 0;
    hard_reset();
    rst_n   = 1'b1;
    restart = 1'b1;
    for (int e = 1; e <= 135; e++) begin
      @(negedge clk);
      checks++;
      if (out_a !== exp_vec(k_a, WA, TA) || out_b !== exp_vec(k_b, WB, TB)) begin
        errors++;
        $display("FAIL held_model edge %0d got %b/%b exp %b/%b", e, out_a,
                 out_b, exp_vec(k_a, WA, TA), exp_vec(k_b, WB, TB));
      end
      if (a_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 3) begin
      errors++;
      $display("FAIL held_done_count got %0d exp 3", done_cnt);
    end
    restart = 1'b0;
  endtask

  task automatic test_random();
    hard_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      restart = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      checks++;
      if (out_a !== exp_vec(k_a, WA, TA)) begin
        errors++;
        $display("FAIL rand_a cyc %0d got %b exp %b", i, out_a,
                 exp_vec(k_a, WA, TA));
      end
      checks++;
      if (out_b !== exp_vec(k_b, WB, TB)) begin
        errors++;
        $display("FAIL rand_b cyc %0d got %b exp %b", i, out_b,
                 exp_vec(k_b, WB, TB));
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_abort();
    test_restart();
    test_restart_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
